// File: rtl/my_wb_sched_pkg.sv
// Shared core constants for the writeback scheduler: data width, register
// address width, register count and the default requester count.
package my_wb_sched_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;
  localparam int NREG     = 32;
  localparam int NREQ_DEF = 3;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // Width of a round-robin pointer able to index n requesters.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-robin successor of requester k among n requesters.
  function automatic int rr_next(input int k, input int n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/my_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester found when searching
// upward from i_ptr, wrapping modulo N. Purely combinational, one-hot output.
module my_rr_arbiter
  import my_wb_sched_pkg::*;
#(
  parameter int N  = NREQ_DEF,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  // Priority search starting at the pointer; the first hit wins.
  always_comb begin
    int   idx;
    logic found;
    o_grant = {N{1'b0}};
    found   = 1'b0;
    for (int off = 0; off < N; off++) begin
      idx = int'(i_ptr) + off;
      if (idx >= N) begin
        idx = idx - N;
      end else begin
        idx = idx + 0;
      end
      for (int k = 0; k < N; k++) begin
        if (!found && i_valid[k] && (k == idx)) begin
          o_grant[k] = 1'b1;
          found      = 1'b1;
        end else begin
          o_grant[k] = o_grant[k];
        end
      end
    end
  end

endmodule

// File: rtl/my_wb_sched.sv
// Writeback scheduler: arbitrates NREQ writeback requesters onto a single
// registered register-file write port, and keeps a busy scoreboard of
// destination registers with pending writes to raise decode hazards.
module my_wb_sched
  import my_wb_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int XLEN = XLEN_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid_i,
  input  logic [REG_AW-1:0]        issue_rd_i,
  input  logic                     flush_i,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [REG_AW*NREQ-1:0]   req_addr_i,
  input  logic [XLEN*NREQ-1:0]     req_data_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [REG_AW-1:0]        rs1_addr_i,
  input  logic [REG_AW-1:0]        rs2_addr_i,
  output logic                     hazard_o,
  output logic                     rf_we_o,
  output logic [REG_AW-1:0]        rf_rd_addr_o,
  output logic [XLEN-1:0]          rf_rd_data_o,
  output logic [NREG-1:0]          busy_o
);

  localparam int PW = ptr_width(NREQ);

  logic [NREQ-1:0]   w_arb_valid;
  logic [NREQ-1:0]   w_grant;
  logic              w_hs;
  logic [PW-1:0]     w_sel;
  reg_addr_t         w_addr;
  logic [XLEN-1:0]   w_data;
  logic [NREG-1:0]   w_set_mask;
  logic [NREG-1:0]   w_clr_mask;
  logic [NREG-1:0]   w_busy_nxt;
  logic              w_haz_rs1;
  logic              w_haz_rs2;

  logic [NREG-1:0]   r_busy;
  logic [PW-1:0]     r_ptr;
  logic              r_we;
  reg_addr_t         r_addr;
  logic [XLEN-1:0]   r_data;

  // A flush hides every request from the arbiter so nothing is accepted.
  assign w_arb_valid = flush_i ? {NREQ{1'b0}} : req_valid_i;

  my_rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_arb (
    .i_valid (w_arb_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  assign req_ready_o = w_grant;
  assign w_hs        = |w_grant;

  // Grant is one-hot, so OR-ing masked fields selects the winner's index,
  // address and data without priority logic.
  always_comb begin
    w_sel  = {PW{1'b0}};
    w_addr = {REG_AW{1'b0}};
    w_data = {XLEN{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      w_sel  = w_sel  | (PW'(k) & {PW{w_grant[k]}});
      w_addr = w_addr | (req_addr_i[REG_AW*k +: REG_AW] & {REG_AW{w_grant[k]}});
      w_data = w_data | (req_data_i[XLEN*k +: XLEN] & {XLEN{w_grant[k]}});
    end
  end

  // Scoreboard next state: flush or clear first, then the issue sets its
  // bit so a newer writer to the same register stays pending; x0 never busy.
  always_comb begin
    w_set_mask = issue_valid_i ? (NREG'(1) << issue_rd_i) : {NREG{1'b0}};
    w_clr_mask = w_hs ? (NREG'(1) << w_addr) : {NREG{1'b0}};
    if (flush_i) begin
      w_busy_nxt = w_set_mask;
    end else begin
      w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // A source is hazardous while its writer is pending or its write is
  // sitting in the output register this cycle; x0 is never hazardous.
  assign w_haz_rs1 = (rs1_addr_i != {REG_AW{1'b0}}) &&
                     (r_busy[rs1_addr_i] || (r_we && (r_addr == rs1_addr_i)));
  assign w_haz_rs2 = (rs2_addr_i != {REG_AW{1'b0}}) &&
                     (r_busy[rs2_addr_i] || (r_we && (r_addr == rs2_addr_i)));
  assign hazard_o  = w_haz_rs1 || w_haz_rs2;

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= {NREG{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Round-robin pointer moves just past the requester that was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= {PW{1'b0}};
    end else if (w_hs) begin
      r_ptr <= PW'(rr_next(int'(w_sel), NREQ));
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Register-file write port: pulse one cycle after a handshake, hold
  // address and data otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_addr <= {REG_AW{1'b0}};
      r_data <= {XLEN{1'b0}};
    end else if (w_hs) begin
      r_we   <= 1'b1;
      r_addr <= w_addr;
      r_data <= w_data;
    end else begin
      r_we   <= 1'b0;
      r_addr <= r_addr;
      r_data <= r_data;
    end
  end

  assign rf_we_o      = r_we;
  assign rf_rd_addr_o = r_addr;
  assign rf_rd_data_o = r_data;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_my_wb_sched.sv
// Self-checking bench for my_wb_sched: directed scenarios with literal
// expectations plus a cycle-by-cycle comparison against a behavioural model.
module tb_my_wb_sched;

  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 issue_valid_i;
  logic [4:0]           issue_rd_i;
  logic                 flush_i;
  logic [NREQ-1:0]      req_valid_i;
  logic [5*NREQ-1:0]    req_addr_i;
  logic [XLEN*NREQ-1:0] req_data_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [4:0]           rs1_addr_i;
  logic [4:0]           rs2_addr_i;
  logic                 hazard_o;
  logic                 rf_we_o;
  logic [4:0]           rf_rd_addr_o;
  logic [XLEN-1:0]      rf_rd_data_o;
  logic [31:0]          busy_o;

  int n_checks = 0;
  int n_errors = 0;

  my_wb_sched #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .flush_i       (flush_i),
    .req_valid_i   (req_valid_i),
    .req_addr_i    (req_addr_i),
    .req_data_i    (req_data_i),
    .req_ready_o   (req_ready_o),
    .rs1_addr_i    (rs1_addr_i),
    .rs2_addr_i    (rs2_addr_i),
    .hazard_o      (hazard_o),
    .rf_we_o       (rf_we_o),
    .rf_rd_addr_o  (rf_rd_addr_o),
    .rf_rd_data_o  (rf_rd_data_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy [32];
  int          m_ptr;
  bit          m_we;
  int          m_addr;
  logic [31:0] m_data;

  function automatic bit model_haz(input int rs);
    return (rs != 0) && (m_busy[rs] || (m_we && (m_addr == rs)));
  endfunction

  // Compare on the falling edge (inputs stable), then advance the model.
  always @(negedge clk) begin : model
    int          g;
    int          k;
    logic [31:0] exp_busy;
    logic [2:0]  exp_ready;
    exp_busy = 32'd0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) exp_busy[i] = 1'b1;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_ptr = 0; m_we = 1'b0; m_addr = 0; m_data = 32'd0;
      check("m_rst_we", {31'd0, rf_we_o}, 32'd0);
      check("m_rst_addr", {27'd0, rf_rd_addr_o}, 32'd0);
      check("m_rst_data", rf_rd_data_o, 32'd0);
      check("m_rst_busy", busy_o, 32'd0);
    end else begin
      g = -1;
      if (!flush_i) begin
        for (int off = 0; off < NREQ; off++) begin
          k = (m_ptr + off) % NREQ;
          if (g < 0 && req_valid_i[k]) g = k;
        end
      end
      exp_ready = 3'd0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("m_ready", {29'd0, req_ready_o}, {29'd0, exp_ready});
      check("m_hazard", {31'd0, hazard_o},
            {31'd0, model_haz(int'(rs1_addr_i)) || model_haz(int'(rs2_addr_i))});
      check("m_we", {31'd0, rf_we_o}, {31'd0, m_we});
      check("m_addr", {27'd0, rf_rd_addr_o}, m_addr[31:0]);
      check("m_data", rf_rd_data_o, m_data);
      check("m_busy", busy_o, exp_busy);
      // advance: flush/clear, then set, then write port
      if (flush_i) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (g >= 0) begin
        m_busy[int'(req_addr_i[5*g +: 5])] = 1'b0;
      end
      if (issue_valid_i && issue_rd_i != 5'd0) m_busy[int'(issue_rd_i)] = 1'b1;
      m_busy[0] = 1'b0;
      if (g >= 0) begin
        m_we   = 1'b1;
        m_addr = int'(req_addr_i[5*g +: 5]);
        m_data = req_data_i[XLEN*g +: XLEN];
        m_ptr  = (g + 1) % NREQ;
      end else begin
        m_we = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    issue_valid_i = 1'b0; issue_rd_i = 5'd0; flush_i = 1'b0;
    req_valid_i = 3'd0; req_addr_i = 15'd0; req_data_i = 96'd0;
    rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state, no traffic
    cyc(); #1;
    check("rst_busy", busy_o, 32'd0);
    check("rst_we", {31'd0, rf_we_o}, 32'd0);
    check("rst_haz", {31'd0, hazard_o}, 32'd0);

    // three requesters valid continuously: grants 0,1,2,0
    cyc();
    req_valid_i = 3'b111;
    req_addr_i  = {5'd3, 5'd2, 5'd1};
    req_data_i  = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1};
    #1 check("rr_g0", {29'd0, req_ready_o}, 32'd1);
    cyc(); #1;
    check("rr_g1", {29'd0, req_ready_o}, 32'd2);
    check("rr_we0", {31'd0, rf_we_o}, 32'd1);
    check("rr_addr0", {27'd0, rf_rd_addr_o}, 32'd1);
    check("rr_data0", rf_rd_data_o, 32'h0000_00A1);
    cyc(); #1;
    check("rr_g2", {29'd0, req_ready_o}, 32'd4);
    check("rr_addr1", {27'd0, rf_rd_addr_o}, 32'd2);
    cyc(); #1;
    check("rr_g3", {29'd0, req_ready_o}, 32'd1);
    check("rr_data2", rf_rd_data_o, 32'h0000_00A3);
    cyc();
    req_valid_i = 3'b000;
    #1 check("rr_addr3", {27'd0, rf_rd_addr_o}, 32'd1);
    cyc(); #1;
    check("rr_we_off", {31'd0, rf_we_o}, 32'd0);
    check("rr_hold", {27'd0, rf_rd_addr_o}, 32'd1);

    // issue rd=5 then read rs1=5; writeback clears with one in-flight cycle
    cyc();
    issue_valid_i = 1'b1; issue_rd_i = 5'd5;
    cyc();
    issue_valid_i = 1'b0; issue_rd_i = 5'd0; rs1_addr_i = 5'd5;
    #1 check("haz_busy5", busy_o, 32'h0000_0020);
    check("haz_set", {31'd0, hazard_o}, 32'd1);
    cyc();
    req_valid_i = 3'b001; req_addr_i = {5'd0, 5'd0, 5'd5}; req_data_i = {64'd0, 32'h0000_0055};
    #1 check("haz_g", {29'd0, req_ready_o}, 32'd1);
    cyc();
    req_valid_i = 3'b000;
    #1 check("haz_inflight", {31'd0, hazard_o}, 32'd1);
    check("haz_busy_clr", busy_o, 32'd0);
    check("haz_we", {31'd0, rf_we_o}, 32'd1);
    cyc(); #1;
    check("haz_drop", {31'd0, hazard_o}, 32'd0);
    rs1_addr_i = 5'd0;

    // issue rd=7 and writeback to 7 together: set wins (pointer is 1)
    cyc();
    issue_valid_i = 1'b1; issue_rd_i = 5'd7;
    req_valid_i = 3'b010; req_addr_i = {5'd0, 5'd7, 5'd0}; req_data_i = {32'd0, 32'h0000_0077, 32'd0};
    #1 check("sw_g", {29'd0, req_ready_o}, 32'd2);
    cyc();
    idle();
    #1 check("sw_busy7", busy_o, 32'h0000_0080);
    check("sw_addr", {27'd0, rf_rd_addr_o}, 32'd7);

    // issue rd=0 and writeback to x0 (pointer is 2)
    cyc();
    issue_valid_i = 1'b1; issue_rd_i = 5'd0;
    req_valid_i = 3'b100; req_addr_i = 15'd0; req_data_i = {32'h0000_0BAD, 64'd0};
    #1 check("x0_g", {29'd0, req_ready_o}, 32'd4);
    cyc();
    idle();
    #1 check("x0_busy", busy_o, 32'h0000_0080);
    check("x0_we", {31'd0, rf_we_o}, 32'd1);
    check("x0_addr", {27'd0, rf_rd_addr_o}, 32'd0);
    check("x0_data", rf_rd_data_o, 32'h0000_0BAD);
    check("x0_haz", {31'd0, hazard_o}, 32'd0);

    // busy {4,7,9} then flush with issue rd=12
    cyc();
    issue_valid_i = 1'b1; issue_rd_i = 5'd4;
    cyc();
    issue_rd_i = 5'd9;
    cyc();
    issue_rd_i = 5'd12; flush_i = 1'b1;
    req_valid_i = 3'b111; req_addr_i = {5'd1, 5'd9, 5'd4};
    #1 check("fl_pre_busy", busy_o, 32'h0000_0290);
    check("fl_ready", {29'd0, req_ready_o}, 32'd0);
    cyc();
    idle();
    #1 check("fl_busy", busy_o, 32'h0000_1000);
    check("fl_we", {31'd0, rf_we_o}, 32'd0);

    // registered write survives a following flush
    cyc();
    req_valid_i = 3'b001; req_addr_i = {5'd0, 5'd0, 5'd12}; req_data_i = {64'd0, 32'h0000_00CC};
    cyc();
    req_valid_i = 3'b010; flush_i = 1'b1;
    #1 check("flc_we", {31'd0, rf_we_o}, 32'd1);
    check("flc_addr", {27'd0, rf_rd_addr_o}, 32'd12);
    check("flc_ready", {29'd0, req_ready_o}, 32'd0);
    cyc();
    idle();

    // reset during an rf_we_o cycle drops the write
    cyc();
    req_valid_i = 3'b001; req_addr_i = {5'd0, 5'd0, 5'd3}; req_data_i = {64'd0, 32'h0000_00DD};
    cyc();
    idle();
    #1 check("rw_we_pre", {31'd0, rf_we_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check("rw_we_async", {31'd0, rf_we_o}, 32'd0);
    check("rw_addr_async", {27'd0, rf_rd_addr_o}, 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc(); #1;
    check("rw_we_post", {31'd0, rf_we_o}, 32'd0);

    // mixed traffic, checked by the model every cycle
    for (int i = 0; i < 80; i++) begin
      cyc();
      req_valid_i   = 3'($urandom_range(0, 7));
      req_addr_i    = 15'($urandom);
      req_data_i    = {$urandom, $urandom, $urandom};
      issue_valid_i = 1'($urandom_range(0, 1));
      issue_rd_i    = 5'($urandom_range(0, 31));
      flush_i       = ($urandom_range(0, 9) == 0);
      rs1_addr_i    = 5'($urandom_range(0, 31));
      rs2_addr_i    = 5'($urandom_range(0, 31));
    end
    cyc();
    idle();
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
